// File: rtl/hilo_divide_sequencer_if.sv
// Pipeline-side and divider-side signals of the HI/LO divide sequencer.
// An op_* is taken in a cycle only when it is high, pipe_stall is low and stall is low; while stall is high the op must be held.
interface hilo_divide_sequencer_if;
    logic        pipe_stall;
    logic        op_div;
    logic        op_divu;
    logic        op_mfhi;
    logic        op_mflo;
    logic        op_mthi;
    logic        op_mtlo;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_busy;
    logic        div_start_s;
    logic        div_start_u;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] hilo_rdata;
    logic        stall;

    modport master (
        output pipe_stall, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo,
        output rs_data, rt_data, div_quotient, div_remainder, div_busy,
        input  div_start_s, div_start_u, div_dividend, div_divisor, hilo_rdata, stall
    );

    modport slave (
        input  pipe_stall, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo,
        input  rs_data, rt_data, div_quotient, div_remainder, div_busy,
        output div_start_s, div_start_u, div_dividend, div_divisor, hilo_rdata, stall
    );
endinterface

// File: rtl/hilo_divide_sequencer.sv
// Launches DIV/DIVU on the external divider, owns HI/LO, and stalls HI/LO
// instructions while a divide is in flight.
module hilo_divide_sequencer (
    input  logic                     clock,
    input  logic                     reset,
    hilo_divide_sequencer_if.slave   bus,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        any_op;
    logic        div_req;
    logic        idle_accept;

    assign any_op  = bus.op_div | bus.op_divu | bus.op_mfhi | bus.op_mflo
                   | bus.op_mthi | bus.op_mtlo;
    assign div_req = bus.op_div | bus.op_divu;
    // Stall is always 0 in IDLE, so only pipe_stall can block an op there.
    assign idle_accept = (state == IDLE) && !bus.pipe_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (idle_accept && div_req) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (!bus.div_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.stall       = (state != IDLE) && any_op;
        bus.div_start_s = (state == LAUNCH) && signed_q;
        bus.div_start_u = (state == LAUNCH) && !signed_q;
        bus.hilo_rdata  = 32'd0;
        if (bus.op_mfhi) begin
            bus.hilo_rdata = hi_q;
        end else if (bus.op_mflo) begin
            bus.hilo_rdata = lo_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            signed_q   <= 1'b0;
        end else begin
            if (idle_accept) begin
                if (div_req) begin
                    dividend_q <= bus.rs_data;
                    divisor_q  <= bus.rt_data;
                    signed_q   <= bus.op_div;
                end
                if (bus.op_mthi) hi_q <= bus.rs_data;
                if (bus.op_mtlo) lo_q <= bus.rs_data;
            end
            // Busy is meaningful only after LAUNCH; its fall marks a valid result.
            if ((state == WAIT) && !bus.div_busy) begin
                lo_q <= bus.div_quotient;
                hi_q <= bus.div_remainder;
            end
        end
    end

    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign dbg_state        = state;
endmodule

// File: doc/hilo_divide_sequencer.md
# hilo_divide_sequencer

Sequences the multi-cycle 32-bit divider and owns the architectural HI/LO registers for the MIPS32 core. It sits in the EX stage beside the ALU and accepts DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the pipeline. It issues a single-cycle start pulse to the divider, tracks the divider's busy flag, and writes the quotient to LO and the remainder to HI. It raises a pipeline stall whenever an instruction depends on, or would disturb, an in-flight divide.

## Interface
- No parameters. Data width is fixed at 32.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pipe_stall  in  1  stall from another hazard source; blocks acceptance of any op this cycle.
- op_div  in  1  EX instruction is DIV (signed).
- op_divu  in  1  EX instruction is DIVU.
- op_mfhi  in  1  EX instruction is MFHI.
- op_mflo  in  1  EX instruction is MFLO.
- op_mthi  in  1  EX instruction is MTHI.
- op_mtlo  in  1  EX instruction is MTLO.
- rs_data  in  32  rs operand: dividend for DIV/DIVU; write data for MTHI/MTLO.
- rt_data  in  32  rt operand: divisor for DIV/DIVU.
- div_quotient  in  32  divider quotient, already sign-corrected.
- div_remainder  in  32  divider remainder.
- div_busy  in  1  divider running; falls in the same cycle its result is valid.
- div_start_s  out  1  one-cycle signed-divide start pulse to the divider.
- div_start_u  out  1  one-cycle unsigned-divide start pulse to the divider.
- div_dividend  out  32  latched dividend presented to the divider.
- div_divisor  out  32  latched divisor presented to the divider.
- hilo_rdata  out  32  HI for MFHI, LO for MFLO, 0 otherwise (combinational).
- stall  out  1  hold the EX stage this cycle.

## Operation
- The pipeline asserts at most one op_* per cycle. Multiple asserted ops are illegal and behaviour is unspecified.
- An op is **accepted** in a cycle when it is asserted, pipe_stall=0 and stall=0.
- State machine with states IDLE, LAUNCH and WAIT:
  - IDLE, DIV/DIVU accepted -> LAUNCH. Latch rs_data into div_dividend, rt_data into div_divisor, and record signedness.
  - LAUNCH -> WAIT unconditionally. div_start_s or div_start_u is high for exactly this cycle.
  - WAIT with div_busy=1 -> stay in WAIT.
  - WAIT with div_busy=0 -> write LO<=div_quotient and HI<=div_remainder at the clock edge, then go to IDLE.
- MTHI/MTLO accepted in IDLE: HI<=rs_data (MTHI) or LO<=rs_data (MTLO) at the clock edge.
- MFHI/MFLO in IDLE: hilo_rdata returns the current register combinationally, with no stall.
- stall = (state != IDLE) AND (any op_* asserted). Only HI/LO ops are held; unrelated instructions proceed during a divide.
- A DIV/DIVU arriving while a divide is in flight stalls until IDLE, then is accepted. The in-flight divide is never aborted.
- Divide by zero gets no special case: HI/LO take whatever the divider returns. For DIVU with divisor 0 this is LO=0xFFFFFFFF and HI=dividend.
- Reset values:
  - state IDLE.
  - HI=0, LO=0.
  - div_start_s=0, div_start_u=0.
  - div_dividend=0, div_divisor=0.
  - stall=0, hilo_rdata=0.
- Reset mid-divide returns to IDLE with HI/LO=0. The divider is reset in the same cycle.

## Timing
- DIV/DIVU accepted in cycle 0:
  - Cycle 1: LAUNCH, start pulse high.
  - Cycles 2-33: WAIT with div_busy=1 (32 iterations).
  - Cycle 34: WAIT with div_busy=0; HI/LO written at the end of the cycle.
  - Cycle 35: IDLE, new values visible.
- MFHI/MFLO arriving in cycles 1-34 sees stall=1, then is accepted in cycle 35 with the new value.
- MTHI/MTLO latency is 1 cycle: a write at the end of cycle N is readable in cycle N+1.
- pipe_stall=1 in cycle 0 suppresses acceptance. The op is re-evaluated each cycle, so no double launch occurs.
- div_busy is ignored in LAUNCH, because the divider raises it only from the next cycle.

## Test plan
- DIVU rs=100, rt=7 -> start_u pulses in cycle 1; stall on a following MFLO for cycles 1-34; LO=14, HI=2 from cycle 35.
- DIV rs=-100 (0xFFFFFF9C), rt=7 -> LO=0xFFFFFFF2 (-14); HI equals div_remainder unchanged.
- MTHI 0xDEADBEEF then MFHI next cycle -> hilo_rdata=0xDEADBEEF with stall=0; MTLO during WAIT stalls until IDLE, then LO is written.
- Back-to-back DIVU 10/3 then DIVU 20/6 -> second start pulse at cycle 36; final LO=3, HI=2; exactly two start pulses total.
- DIVU with pipe_stall=1 for 3 cycles -> no start pulse until the cycle after pipe_stall falls; exactly one pulse.
- Reset asserted in cycle 20 of a divide -> next cycle IDLE, HI=LO=0, stall=0; MFLO returns 0.
